// File: rtl/uart_pkg.sv
// UART receive shared definitions: rx FSM states, oversampling constants, vote helper.
// No ports; imported by uart_rx_bit_filter and uart_rx_deserializer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int OVERSAMPLE    = 16;
  localparam int SAMPLE_PHASE  = 7;
  localparam int MAX_DATA_BITS = 8;

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_bit_filter.sv
// RX synchroniser plus optional 2-of-3 vote (UART_RX_MAJORITY_VOTE_EN).
// Ports: clk, rst_n, [tick], rx in; rx_sync (synced line), rx_bit (decision value) out.
module uart_rx_bit_filter
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef UART_RX_MAJORITY_VOTE_EN
  input  logic tick,
`endif
  input  logic rx,
  output logic rx_sync,
  output logic rx_bit
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Samples from the two previous ticks; voted with the
  // current one, so the decision lands one tick later.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hist_q <= '1;
    else if (tick) hist_q <= {hist_q[0], rx_sync};
  end

  assign rx_bit = maj3(hist_q[1], hist_q[0], rx_sync);
`else
  assign rx_bit = rx_sync;
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive stage: 16x oversampled start detect, deserialise, hold byte + status.
// Ports: CLK, RESET_N, BAUD_CLOCK, RX, BIT8, PARITY_EN, ODD_N_EVEN, READ_RX_BYTE in;
//        RX_DATA[7:0], RX_RDY, PARITY_ERR, FRAMING_ERR, OVERFLOW out.
// Option: UART_RX_MAJORITY_VOTE_EN moves decisions to phase 8 using a 3-sample vote.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BAUD_CLOCK,
  input  logic       RX,
  input  logic       BIT8,
  input  logic       PARITY_EN,
  input  logic       ODD_N_EVEN,
  input  logic       READ_RX_BYTE,
  output logic [7:0] RX_DATA,
  output logic       RX_RDY,
  output logic       PARITY_ERR,
  output logic       FRAMING_ERR,
  output logic       OVERFLOW
);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] DECIDE = 4'(SAMPLE_PHASE + 1);
`else
  localparam logic [3:0] DECIDE = 4'(SAMPLE_PHASE);
`endif
  localparam logic [3:0] LAST_PH = 4'(OVERSAMPLE - 1);

  logic rx_sync;
  logic rx_bit;

  uart_rx_bit_filter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_filter (
    .clk    (CLK),
    .rst_n  (RESET_N),
`ifdef UART_RX_MAJORITY_VOTE_EN
    .tick   (BAUD_CLOCK),
`endif
    .rx     (RX),
    .rx_sync(rx_sync),
    .rx_bit (rx_bit)
  );

  rx_state_e  state_q;
  logic [3:0] phase_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       perr_q;
  logic       load_q;

  logic       decide;
  logic       wrap;
  logic       last_bit;
  logic [7:0] data_w;

  assign decide   = (phase_q == DECIDE);
  assign wrap     = (phase_q == LAST_PH);
  assign last_bit = (bit_q == (BIT8 ? 3'(MAX_DATA_BITS - 1)
                                    : 3'(MAX_DATA_BITS - 2)));
  // 7-bit frames stop one shift short of bit 0.
  assign data_w   = BIT8 ? shift_q : {1'b0, shift_q[7:1]};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      load_q      <= 1'b0;
      FRAMING_ERR <= 1'b0;
    end else begin
      load_q      <= 1'b0;
      FRAMING_ERR <= 1'b0;
      if (BAUD_CLOCK) begin
        phase_q <= phase_q + 4'd1;
        unique case (state_q)
          ST_IDLE: begin
            phase_q <= '0;
            if (!rx_sync) begin
              state_q <= ST_START;
              perr_q  <= 1'b0;
            end
          end
          ST_START: begin
            if (decide && rx_bit) begin
              state_q <= ST_IDLE;
              phase_q <= '0;
            end else if (wrap) begin
              state_q <= ST_DATA;
              bit_q   <= '0;
            end
          end
          ST_DATA: begin
            if (decide) shift_q <= {rx_bit, shift_q[7:1]};
            if (wrap) begin
              if (last_bit)
                state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
              else
                bit_q <= bit_q + 3'd1;
            end
          end
          ST_PARITY: begin
            if (decide)
              perr_q <= rx_bit ^ (^data_w) ^ ODD_N_EVEN;
            if (wrap) state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (decide) begin
              state_q     <= ST_IDLE;
              phase_q     <= '0;
              load_q      <= 1'b1;
              FRAMING_ERR <= !rx_bit;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RX_DATA    <= '0;
      RX_RDY     <= 1'b0;
      PARITY_ERR <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else if (load_q) begin
      if (!RX_RDY || READ_RX_BYTE) begin
        RX_DATA    <= data_w;
        PARITY_ERR <= perr_q;
        RX_RDY     <= 1'b1;
        if (READ_RX_BYTE) OVERFLOW <= 1'b0;
      end else begin
        OVERFLOW <= 1'b1;
      end
    end else if (READ_RX_BYTE) begin
      RX_RDY     <= 1'b0;
      PARITY_ERR <= 1'b0;
      OVERFLOW   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frame-level line model,
// directed vector table, corner sequences and randomized frames.
module tb_uart_rx_deserializer;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       BAUD_CLOCK = 1'b0;
  logic       RX = 1'b1;
  logic       BIT8 = 1'b1;
  logic       PARITY_EN = 1'b0;
  logic       ODD_N_EVEN = 1'b0;
  logic       READ_RX_BYTE = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_RDY;
  logic       PARITY_ERR;
  logic       FRAMING_ERR;
  logic       OVERFLOW;

  int n_chk = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  logic [1:0] bcnt = '0;

  uart_rx_deserializer #(.SYNC_STAGES(2)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .BAUD_CLOCK  (BAUD_CLOCK),
    .RX          (RX),
    .BIT8        (BIT8),
    .PARITY_EN   (PARITY_EN),
    .ODD_N_EVEN  (ODD_N_EVEN),
    .READ_RX_BYTE(READ_RX_BYTE),
    .RX_DATA     (RX_DATA),
    .RX_RDY      (RX_RDY),
    .PARITY_ERR  (PARITY_ERR),
    .FRAMING_ERR (FRAMING_ERR),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // 16x tick every 4 CLK, changed on the falling edge
  always @(negedge CLK) begin
    bcnt = bcnt + 2'd1;
    BAUD_CLOCK = (bcnt == 2'd0);
  end

  always @(posedge CLK)
    if (RESET_N && FRAMING_ERR === 1'b1) fe_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge CLK); while (BAUD_CLOCK !== 1'b1);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  // Line waveform at tick granularity: 16 ticks per bit.
  task automatic send_frame(input logic [7:0] d, input bit b8,
                            input bit pen, input bit odd,
                            input bit flip, input bit stop_ok,
                            input int glitch_t = -1);
    bit w[$];
    int nb;
    bit p;
    nb = b8 ? 8 : 7;
    p = odd;
    BIT8 = b8;
    PARITY_EN = pen;
    ODD_N_EVEN = odd;
    repeat (16) w.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      p = p ^ d[i];
      repeat (16) w.push_back(d[i]);
    end
    if (pen) repeat (16) w.push_back(p ^ flip);
    if (stop_ok) begin
      repeat (16) w.push_back(1'b1);
    end else begin
      repeat (11) w.push_back(1'b0);
      repeat (5) w.push_back(1'b1);
    end
    repeat (24) w.push_back(1'b1);
    if (glitch_t >= 0) w[glitch_t] = ~w[glitch_t];
    wait_tick();
    foreach (w[t]) begin
      RX = w[t];
      wait_tick();
    end
  endtask

  task automatic do_read();
    @(negedge CLK);
    READ_RX_BYTE = 1'b1;
    @(negedge CLK);
    READ_RX_BYTE = 1'b0;
    @(negedge CLK);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         b8;
    bit         pen;
    bit         odd;
    bit         flip;
    bit         stop_ok;
    logic [7:0] exp_d;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[8];

  task automatic run_frame(input string tag, input vec_t v);
    int fe0;
    fe0 = fe_cnt;
    send_frame(v.d, v.b8, v.pen, v.odd, v.flip, v.stop_ok);
    @(negedge CLK);
    chk({tag, " data"}, RX_DATA, v.exp_d);
    chk({tag, " rdy"}, RX_RDY, 1);
    chk({tag, " perr"}, PARITY_ERR, v.exp_pe);
    chk({tag, " ovf"}, OVERFLOW, 0);
    chk({tag, " fe_pulses"}, fe_cnt - fe0, v.exp_fe);
    do_read();
    chk({tag, " rdy_clr"}, RX_RDY, 0);
    chk({tag, " perr_clr"}, PARITY_ERR, 0);
  endtask

  initial begin
    logic [7:0] rd;
    vec_t rv;
    logic [7:0] glitch_exp;

    vecs[0] = '{8'hA5, 1, 0, 0, 0, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h41, 0, 1, 0, 0, 1, 8'h41, 0, 0};
    vecs[2] = '{8'h41, 0, 1, 0, 1, 1, 8'h41, 1, 0};
    vecs[3] = '{8'h7E, 1, 0, 0, 0, 0, 8'h7E, 0, 1};
    vecs[4] = '{8'hFF, 0, 0, 0, 0, 1, 8'h7F, 0, 0};
    vecs[5] = '{8'h00, 1, 1, 1, 0, 1, 8'h00, 0, 0};
    vecs[6] = '{8'hC3, 1, 1, 0, 1, 1, 8'hC3, 1, 0};
    vecs[7] = '{8'h80, 0, 0, 0, 0, 1, 8'h00, 0, 0};

    repeat (5) @(negedge CLK);
    chk("reset data", RX_DATA, 0);
    chk("reset rdy", RX_RDY, 0);
    chk("reset perr", PARITY_ERR, 0);
    chk("reset fe", FRAMING_ERR, 0);
    chk("reset ovf", OVERFLOW, 0);
    RESET_N = 1'b1;
    wait_ticks(4);

    foreach (vecs[i]) run_frame($sformatf("vec%0d", i), vecs[i]);

    // false start: 5 ticks low
    wait_tick();
    RX = 1'b0;
    wait_ticks(5);
    RX = 1'b1;
    wait_ticks(30);
    chk("false_start rdy", RX_RDY, 0);
    chk("false_start fe", FRAMING_ERR, 0);
    run_frame("after_false", '{8'h3C, 1, 0, 0, 0, 1, 8'h3C, 0, 0});

    // overflow: two frames without a read
    send_frame(8'h11, 1, 0, 0, 0, 1);
    send_frame(8'h22, 1, 0, 0, 0, 1);
    @(negedge CLK);
    chk("ovf data", RX_DATA, 8'h11);
    chk("ovf rdy", RX_RDY, 1);
    chk("ovf flag", OVERFLOW, 1);
    do_read();
    chk("ovf rdy_clr", RX_RDY, 0);
    chk("ovf flag_clr", OVERFLOW, 0);

    // one-tick glitch on the phase-7 sample of bit 3
`ifdef UART_RX_MAJORITY_VOTE_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    send_frame(8'h00, 1, 0, 0, 0, 1, 16 * 4 + 8);
    @(negedge CLK);
    chk("glitch data", RX_DATA, glitch_exp);
    chk("glitch rdy", RX_RDY, 1);
    do_read();

    // reset mid-frame with a held byte
    send_frame(8'h5A, 1, 0, 0, 0, 1);
    wait_tick();
    RX = 1'b0;
    wait_ticks(40);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("midrst data", RX_DATA, 0);
    chk("midrst rdy", RX_RDY, 0);
    chk("midrst perr", PARITY_ERR, 0);
    chk("midrst fe", FRAMING_ERR, 0);
    chk("midrst ovf", OVERFLOW, 0);
    RX = 1'b1;
    repeat (4) @(negedge CLK);
    RESET_N = 1'b1;
    wait_ticks(8);
    chk("post_rst rdy", RX_RDY, 0);
    run_frame("post_rst", '{8'hA3, 1, 0, 0, 0, 1, 8'hA3, 0, 0});

    // randomized frames against the frame-level model
    for (int k = 0; k < 16; k++) begin
      rd = 8'($urandom);
      rv.d = rd;
      rv.b8 = 1'($urandom_range(0, 1));
      rv.pen = 1'($urandom_range(0, 1));
      rv.odd = 1'($urandom_range(0, 1));
      rv.flip = rv.pen & 1'($urandom_range(0, 1));
      rv.stop_ok = ($urandom_range(0, 3) != 0);
      rv.exp_d = rv.b8 ? rd : {1'b0, rd[6:0]};
      rv.exp_pe = rv.pen & rv.flip;
      rv.exp_fe = !rv.stop_ok;
      run_frame($sformatf("rnd%0d", k), rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
